// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared UART timing constants, state encoding and datapath select codes
package uart_tx_pkg;
  localparam int CLK_PERIOD = 10;
  localparam int UART_BAUD_PERIOD = 8680;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
  typedef enum logic [1:0] {CNT_CLR = 2'd0, CNT_HOLD = 2'd1, CNT_INC = 2'd2} cnt_sel_t;
  typedef enum logic [1:0] {SR_HOLD = 2'd0, SR_LOAD = 2'd1, SR_SHIFT = 2'd2} sr_sel_t;
endpackage

// File: rtl/uart_tx_datapath.sv
// uart_tx_datapath: load/shift register, baud and bit counters, terminal-count flags
module uart_tx_datapath
  import uart_tx_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int WORD_SIZE_WIDTH = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  cnt_sel_t             baud_sel,
  input  cnt_sel_t             bit_sel,
  input  sr_sel_t              sr_sel,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] shift_reg,
  output logic                 baud_tc,
  output logic                 last_bit
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  logic [BW-1:0] baud_cnt;
  logic [WORD_SIZE_WIDTH-1:0] bit_cnt;
  always_ff @(posedge clk) begin
    if (reset_b) begin
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift_reg <= '0;
    end else begin
      baud_cnt <= baud_sel == CNT_CLR ? '0 : baud_sel == CNT_INC ? baud_cnt + 1'b1 : baud_cnt;
      bit_cnt <= bit_sel == CNT_CLR ? '0 : bit_sel == CNT_INC ? bit_cnt + 1'b1 : bit_cnt;
      shift_reg <= sr_sel == SR_LOAD ? data_in : sr_sel == SR_SHIFT ? shift_reg >> 1 : shift_reg;
    end
  end
  assign baud_tc = baud_cnt == BW'(CLKS_PER_BIT - 1);
  assign last_bit = bit_cnt == WORD_SIZE_WIDTH'(WORD_SIZE - 1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, idle-high line, registered outputs
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int WORD_SIZE_WIDTH = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 TX_Start,
  input  logic [WORD_SIZE-1:0] TX_Data_in,
  output logic                 TX_Serial_out,
  output logic                 TX_Busy,
  output logic                 TX_Done
);
  state_t state, state_n;
  cnt_sel_t baud_sel, bit_sel;
  sr_sel_t sr_sel;
  logic [WORD_SIZE-1:0] shift_reg;
  logic baud_tc, last_bit, line_n;
  uart_tx_datapath #(
    .WORD_SIZE(WORD_SIZE),
    .WORD_SIZE_WIDTH(WORD_SIZE_WIDTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_dp (
    .clk(clk),
    .reset_b(reset_b),
    .baud_sel(baud_sel),
    .bit_sel(bit_sel),
    .sr_sel(sr_sel),
    .data_in(TX_Data_in),
    .shift_reg(shift_reg),
    .baud_tc(baud_tc),
    .last_bit(last_bit)
  );
  always_ff @(posedge clk) begin
    if (reset_b) begin
      state <= IDLE;
      TX_Serial_out <= 1'b1;
      TX_Busy <= 1'b0;
      TX_Done <= 1'b0;
    end else begin
      state <= state_n;
      TX_Serial_out <= line_n;
      TX_Busy <= state_n != IDLE;
      TX_Done <= state == STOP && baud_tc;
    end
  end
  always_comb begin
    state_n = state;
    baud_sel = (state == IDLE || baud_tc) ? CNT_CLR : CNT_INC;
    bit_sel = CNT_HOLD;
    sr_sel = SR_HOLD;
    case (state)
      IDLE: if (TX_Start) begin
        state_n = START;
        bit_sel = CNT_CLR;
        sr_sel = SR_LOAD;
      end
      START: if (baud_tc) state_n = DATA;
      DATA: if (baud_tc) begin
        sr_sel = SR_SHIFT;
        bit_sel = CNT_INC;
        if (last_bit) state_n = STOP;
      end
      STOP: if (baud_tc) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // the pin flop is loaded with the bit the line must carry after this edge
    line_n = state_n == START ? 1'b0 :
             state_n == DATA ? (sr_sel == SR_SHIFT ? shift_reg[1] : shift_reg[0]) : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed stimulus against a frame-timing model of 8N1 transmission
module tb_uart_tx;
  localparam int C = 4;
  localparam int CB = 868;
  logic clk = 0, rst = 1, start = 0, start_b = 0;
  logic [7:0] din = 0, din_b = 0;
  logic ser, busy, done, ser_b, busy_b, done_b;
  int total = 0, bad = 0;
  bit en = 0;
  always #5 clk = ~clk;
  uart_tx #(.WORD_SIZE(8), .WORD_SIZE_WIDTH(4), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset_b(rst), .TX_Start(start), .TX_Data_in(din),
    .TX_Serial_out(ser), .TX_Busy(busy), .TX_Done(done));
  uart_tx #(.WORD_SIZE(8), .WORD_SIZE_WIDTH(4), .CLKS_PER_BIT(CB)) dut_b (
    .clk(clk), .reset_b(rst), .TX_Start(start_b), .TX_Data_in(din_b),
    .TX_Serial_out(ser_b), .TX_Busy(busy_b), .TX_Done(done_b));
  // model: m_t counts cycles since the accepting edge; a frame occupies 10*C of them
  bit m_act = 0, m_done = 0;
  int m_t = 0;
  logic [7:0] m_data = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_act = 0;
      m_done = 0;
    end else if (m_act) begin
      m_t++;
      m_done = m_t == 10 * C;
      if (m_done) m_act = 0;
    end else begin
      m_done = 0;
      if (start) begin
        m_act = 1;
        m_t = 0;
        m_data = din;
      end
    end
  end
  function automatic logic m_line();
    int idx;
    if (!m_act) return 1'b1;
    idx = m_t / C;
    return idx == 0 ? 1'b0 : idx <= 8 ? m_data[idx-1] : 1'b1;
  endfunction
  int busy_cnt = 0, done_cnt = 0, hi_cnt = 0, busy_b_cnt = 0, low_b_cnt = 0, done_b_cnt = 0;
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    if (ser === 1'b1) hi_cnt++;
    if (busy_b === 1'b1) busy_b_cnt++;
    if (ser_b === 1'b0) low_b_cnt++;
    if (done_b === 1'b1) done_b_cnt++;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d);
    @(posedge clk);
    #1 start = 1;
    din = d;
    tick(1);
    start = 0;
  endtask
  initial begin
    int b0, d0, h0, n, g;
    logic [9:0] got;
    fork
      forever begin
        @(negedge clk);
        if (en) begin
          check("cyc_line", ser, m_line());
          check("cyc_busy", busy, m_act);
          check("cyc_done", done, m_done);
        end
      end
    join_none
    tick(3);
    en = 1;
    rst = 0;
    b0 = busy_cnt; d0 = done_cnt; h0 = hi_cnt;
    tick(20);
    check("idle_busy", busy_cnt - b0, 0);
    check("idle_done", done_cnt - d0, 0);
    check("idle_high", hi_cnt - h0, 20);
    b0 = busy_cnt; d0 = done_cnt;
    send(8'hA5);
    for (int k = 0; k < 10 * C; k++) begin
      @(negedge clk);
      if (k % C == 1) got[k/C] = ser;
    end
    tick(2);
    check("a5_bits", got, 10'h34A);
    check("a5_busy", busy_cnt - b0, 40);
    check("a5_done", done_cnt - d0, 1);
    b0 = busy_cnt; d0 = done_cnt;
    send(8'h3C);
    tick(9);
    start = 1;
    din = 8'hFF;
    tick(1);
    start = 0;
    din = 8'h00;
    tick(40);
    check("busy_ign_busy", busy_cnt - b0, 40);
    check("busy_ign_done", done_cnt - d0, 1);
    @(posedge clk);
    #1 start = 1;
    din = 8'h00;
    tick(1);
    din = 8'hFF;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin tick(1); n++; end
    g = 0;
    while (busy !== 1'b1 && g < 100) begin tick(1); g++; end
    start = 0;
    check("b2b_end", n < 100, 1);
    check("b2b_gap", g, 1);
    tick(45);
    d0 = done_cnt;
    send(8'h55);
    tick(4 * C + 1);
    rst = 1;
    tick(1);
    rst = 0;
    check("rst_line", ser, 1);
    check("rst_busy", busy, 0);
    tick(3);
    check("rst_nodone", done_cnt - d0, 0);
    b0 = busy_cnt;
    send(8'h81);
    tick(10 * C + 2);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_busy", busy_cnt - b0, 40);
    b0 = busy_b_cnt; h0 = low_b_cnt; d0 = done_b_cnt;
    @(posedge clk);
    #1 start_b = 1;
    din_b = 8'h00;
    tick(1);
    start_b = 0;
    tick(10 * CB + 20);
    check("baud_low", low_b_cnt - h0, 9 * CB);
    check("baud_busy", busy_b_cnt - b0, 10 * CB);
    check("baud_done", done_b_cnt - d0, 1);
    en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
